// File: rtl/spi_txn_scheduler.sv
// spi_txn_scheduler: round-robin owner of the SPI interface register port.
// Grants one of two requesters, writes its tx bytes to the SPI data memory,
// starts the transfer, polls the send bit, reads rx bytes back and acks.
module spi_txn_scheduler #(
  parameter int POLL_GAP      = 16,
  parameter int TIMEOUT_POLLS = 1024
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic [1:0]  len0_i,
  input  logic [1:0]  len1_i,
  input  logic [31:0] tdata0_i,
  input  logic [31:0] tdata1_i,
  output logic        ack0_o,
  output logic        ack1_o,
  output logic [31:0] rdata0_o,
  output logic [31:0] rdata1_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        wr_o,
  output logic        reg_sel_o,
  output logic [31:0] addr_o,
  output logic [31:0] entrada_o,
  input  logic [31:0] salida_i
);

  localparam int PW = $clog2(TIMEOUT_POLLS + 1);
  localparam int GW = $clog2(POLL_GAP + 1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    WR_DATA   = 4'd1,
    WR_CTRL   = 4'd2,
    POLL_SET  = 4'd3,
    POLL_CHK  = 4'd4,
    POLL_WAIT = 4'd5,
    RD_SET    = 4'd6,
    RD_CAP    = 4'd7,
    ABORT     = 4'd8,
    DONE      = 4'd9
  } state_t;

  state_t        state_q, state_d;
  logic          gnt_q, gnt_d;      // 0 = requester 0, 1 = requester 1
  logic          last_q, last_d;    // last requester served
  logic [1:0]    len_q, len_d;
  logic [31:0]   tdata_q, tdata_d;
  logic [1:0]    k_q, k_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [31:0]   rx_q, rx_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          err_q, err_d;
  logic [31:0]   rdata0_q, rdata0_d;
  logic [31:0]   rdata1_q, rdata1_d;

  logic          wr_s;
  logic          reg_sel_s;
  logic [31:0]   addr_s;
  logic [31:0]   entrada_s;
  logic [31:0]   ctrl_word_s;
  logic          unused_salida_s;

  // Only the low byte (data) and bit 0 (send) of the read port matter.
  assign unused_salida_s = ^salida_i[31:8];

  // Start word: send=1, pattern bits 0, n_tx_end = L-1 in bits [12:4].
  assign ctrl_word_s = {19'd0, 7'd0, len_q, 4'b0001};

  // Next-state, datapath and SPI register-port decode.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    len_d     = len_q;
    tdata_d   = tdata_q;
    k_d       = k_q;
    poll_d    = poll_q;
    gap_d     = gap_q;
    rx_d      = rx_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    err_d     = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    wr_s      = 1'b0;
    reg_sel_s = 1'b0;
    addr_s    = 32'd0;
    entrada_s = 32'd0;

    case (state_q)
      IDLE: begin
        if (req0_i || req1_i) begin
          // Both requesting: serve the one not served last.
          gnt_d   = (req0_i && req1_i) ? ~last_q : ~req0_i;
          len_d   = gnt_d ? len1_i : len0_i;
          tdata_d = gnt_d ? tdata1_i : tdata0_i;
          k_d     = 2'd0;
          poll_d  = '0;
          gap_d   = '0;
          rx_d    = 32'd0;
          state_d = WR_DATA;
        end else begin
          state_d = IDLE;
        end
      end
      WR_DATA: begin
        wr_s      = 1'b1;
        reg_sel_s = 1'b1;
        addr_s    = {30'd0, k_q};
        entrada_s = {24'd0, tdata_q[{k_q, 3'b000} +: 8]};
        if (k_q == len_q) begin
          k_d     = 2'd0;
          state_d = WR_CTRL;
        end else begin
          k_d     = k_q + 2'd1;
        end
      end
      WR_CTRL: begin
        wr_s      = 1'b1;
        entrada_s = ctrl_word_s;
        state_d   = POLL_SET;
      end
      POLL_SET: begin
        state_d = POLL_CHK;
      end
      POLL_CHK: begin
        if (!salida_i[0]) begin
          k_d     = 2'd0;
          state_d = RD_SET;
        end else if (poll_q == PW'(TIMEOUT_POLLS - 1)) begin
          poll_d  = poll_q + PW'(1);
          state_d = ABORT;
        end else begin
          poll_d  = poll_q + PW'(1);
          gap_d   = '0;
          state_d = POLL_WAIT;
        end
      end
      POLL_WAIT: begin
        if (gap_q == GW'(POLL_GAP - 1)) begin
          gap_d   = '0;
          state_d = POLL_SET;
        end else begin
          gap_d   = gap_q + GW'(1);
        end
      end
      RD_SET: begin
        reg_sel_s = 1'b1;
        addr_s    = {30'd0, k_q};
        state_d   = RD_CAP;
      end
      RD_CAP: begin
        reg_sel_s = 1'b1;
        addr_s    = {30'd0, k_q};
        rx_d[{k_q, 3'b000} +: 8] = salida_i[7:0];
        if (k_q == len_q) begin
          // Ack and result are registered so they appear together in DONE.
          if (gnt_q) begin
            ack1_d   = 1'b1;
            rdata1_d = rx_d;
          end else begin
            ack0_d   = 1'b1;
            rdata0_d = rx_d;
          end
          state_d = DONE;
        end else begin
          k_d     = k_q + 2'd1;
          state_d = RD_SET;
        end
      end
      ABORT: begin
        // Writing control word 0 cancels the pending transfer.
        wr_s      = 1'b1;
        entrada_s = 32'd0;
        err_d     = 1'b1;
        if (gnt_q) begin
          ack1_d   = 1'b1;
          rdata1_d = 32'd0;
        end else begin
          ack0_d   = 1'b1;
          rdata0_d = 32'd0;
        end
        state_d = DONE;
      end
      DONE: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      len_q    <= 2'd0;
      tdata_q  <= 32'd0;
      k_q      <= 2'd0;
      poll_q   <= '0;
      gap_q    <= '0;
      rx_q     <= 32'd0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata0_q <= 32'd0;
      rdata1_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      len_q    <= len_d;
      tdata_q  <= tdata_d;
      k_q      <= k_d;
      poll_q   <= poll_d;
      gap_q    <= gap_d;
      rx_q     <= rx_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign ack0_o    = ack0_q;
  assign ack1_o    = ack1_q;
  assign err_o     = err_q;
  assign rdata0_o  = rdata0_q;
  assign rdata1_o  = rdata1_q;
  assign busy_o    = (state_q != IDLE);
  assign wr_o      = wr_s;
  assign reg_sel_o = reg_sel_s;
  assign addr_o    = addr_s;
  assign entrada_o = entrada_s;

endmodule
